// File: rtl/fft_out_reorder_pkg.sv
// fft_out_reorder_pkg
//   Constants and helpers shared by the FFT-output reorder buffer.
//   The default frame geometry is the same one the FFT core and the UART
//   serialiser stage use. The package also holds the read-FSM state
//   encoding and a bit-reversal helper.
package fft_out_reorder_pkg;

    localparam int DEF_BIT_WIDTH = 28;
    localparam int DEF_N         = 32;
    localparam int DEF_SIZE      = 5;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2
    } rd_state_t;

    // Reverse the low 'size' bits of v. The loop bound is constant, so
    // synthesis unrolls it. Callers cast the result to their address width.
    function automatic int bitrev(input int v, input int size);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < size) r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_ram.sv
// reorder_bank_ram
//   Simple dual-port RAM that holds both ping-pong banks. The bank number
//   is the address MSB. Write is synchronous. The read port is registered
//   with 1-cycle latency.
//   The read register also serves as the block's data output register. For
//   that reason it resets to 0 and holds its value when re is low. The
//   array contents are never reset.
//   Ports: clk, rst_n | we, waddr, wdata | re, raddr, rdata
module reorder_bank_ram #(
    parameter int DW = 56,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Ping-pong reorder buffer between the FFT core and the UART stage.
//   Bit-reversed input samples are written to bank[wr_bank] at bitrev(wr_cnt).
//   Each full bank is read back at natural addresses 0..N-1 as a gap-free
//   burst. The burst starts only when the sink reports it is idle.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     in_valid_i, data_re/im_i       bit-reversed input samples
//     in_ready_o                     current write bank is free
//     sink_ready_i                   downstream can take a whole frame
//     out_valid_o, out_re/im_o       natural-order samples
//     sof_o / eof_o                  marks bin 0 / bin N-1
//     overflow_o                     sticky, set when a sample is dropped
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int N         = DEF_N,
    parameter int SIZE      = DEF_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    input  logic [bit_width-1:0] data_re_i,
    input  logic [bit_width-1:0] data_im_i,
    output logic                 in_ready_o,
    input  logic                 sink_ready_i,
    output logic                 out_valid_o,
    output logic [bit_width-1:0] out_re_o,
    output logic [bit_width-1:0] out_im_o,
    output logic                 sof_o,
    output logic                 eof_o,
    output logic                 overflow_o
);

    localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

    logic            wr_bank;
    logic [SIZE-1:0] wr_cnt;
    logic [1:0]      bank_full;
    rd_state_t       rd_state;
    logic            rd_bank;
    logic [SIZE-1:0] rd_cnt;

    logic            wr_acc, wr_last;
    logic [SIZE-1:0] wr_addr;
    logic            rd_start, rd_issue, rd_last;
    logic [SIZE-1:0] rd_addr;

    // Write side. The registered full flag decides acceptance, so a bank the
    // reader frees this cycle does not accept a sample until next cycle.
    assign in_ready_o = !bank_full[wr_bank];
    assign wr_acc     = in_valid_i && in_ready_o;
    assign wr_last    = wr_acc && (wr_cnt == LAST);
    assign wr_addr    = SIZE'(bitrev(int'(wr_cnt), SIZE));

    // Address 0 goes out in the same cycle the FSM decides to burst, which
    // removes one cycle of latency. A start from IDLE waits while eof_o is
    // high. This leaves one idle output cycle between back-to-back bursts.
    assign rd_start = sink_ready_i &&
                      ((rd_state == RD_IDLE && bank_full[rd_bank] && !eof_o) ||
                       rd_state == RD_WAIT);
    assign rd_issue = rd_start || (rd_state == RD_BURST);
    assign rd_addr  = rd_start ? '0 : rd_cnt;
    assign rd_last  = (rd_state == RD_BURST) && (rd_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            bank_full  <= 2'b00;
            overflow_o <= 1'b0;
        end else begin
            if (wr_acc) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
            if (in_valid_i && !in_ready_o) overflow_o <= 1'b1;
            // Ping-pong guarantees that set and clear hit different banks.
            for (int b = 0; b < 2; b++) begin
                if (wr_last && wr_bank == b[0])      bank_full[b] <= 1'b1;
                else if (rd_last && rd_bank == b[0]) bank_full[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= RD_IDLE;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            out_valid_o <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
        end else begin
            out_valid_o <= rd_issue;
            sof_o       <= rd_issue && (rd_addr == '0);
            eof_o       <= rd_issue && (rd_addr == LAST);
            case (rd_state)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_state <= RD_BURST;
                        rd_cnt   <= SIZE'(1);
                    end else if (bank_full[rd_bank] && !eof_o) begin
                        rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_start) begin
                        rd_state <= RD_BURST;
                        rd_cnt   <= SIZE'(1);
                    end
                end
                RD_BURST: begin
                    // sink_ready_i is ignored here; the burst always completes.
                    if (rd_last) begin
                        rd_state <= RD_IDLE;
                        rd_cnt   <= '0;
                        rd_bank  <= ~rd_bank;
                    end else begin
                        rd_cnt   <= rd_cnt + 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    reorder_bank_ram #(
        .DW(2 * bit_width),
        .AW(SIZE + 1)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_acc),
        .waddr({wr_bank, wr_addr}),
        .wdata({data_re_i, data_im_i}),
        .re   (rd_issue),
        .raddr({rd_bank, rd_addr}),
        .rdata({out_re_o, out_im_o})
    );

endmodule
